button_event_gen: RTL and testbench



---
 rtl/button_event_gen_pkg.sv | 15 +
 rtl/button_event_gen.sv | 140 ++++++++++++++
 tb/tb_button_event_gen.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/button_event_gen_pkg.sv
// Shared input-path definitions: button FSM state encoding and default
// hold/repeat timing for the board clock.
package button_event_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_PRESSED   = 2'd1,
    ST_REPEATING = 2'd2
  } btn_state_e;

  // Board clock defaults; each instance may override them.
  localparam int unsigned DEFAULT_LONG_CYCLES   = 1000;
  localparam int unsigned DEFAULT_REPEAT_CYCLES = 250;

endpackage

// File: rtl/button_event_gen.sv
// Turns a debounced button level into one-cycle press / release / long-press /
// auto-repeat pulses plus held and long_held status levels.
module button_event_gen
  import button_event_gen_pkg::*;
#(
  parameter int unsigned CNT_WIDTH     = 16,
  parameter int unsigned LONG_CYCLES   = DEFAULT_LONG_CYCLES,
  parameter int unsigned REPEAT_CYCLES = DEFAULT_REPEAT_CYCLES,
  parameter bit          REPEAT_EN     = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic in,
  output logic press,
  // release/repeat are language keywords, hence the _evt suffix
  output logic release_evt,
  output logic long_press,
  output logic repeat_evt,
  output logic held,
  output logic long_held
);

  if (CNT_WIDTH < 1 || CNT_WIDTH > 32) begin : g_bad_width
    $error("button_event_gen: CNT_WIDTH must be 1..32");
  end
  if (LONG_CYCLES < 2 || 64'(LONG_CYCLES) > (64'd1 << CNT_WIDTH)) begin : g_bad_long
    $error("button_event_gen: LONG_CYCLES must be 2..2**CNT_WIDTH");
  end
  if (REPEAT_CYCLES < 2 || 64'(REPEAT_CYCLES) > (64'd1 << CNT_WIDTH)) begin : g_bad_repeat
    $error("button_event_gen: REPEAT_CYCLES must be 2..2**CNT_WIDTH");
  end

  localparam logic [CNT_WIDTH-1:0] LONG_LAST   = CNT_WIDTH'(LONG_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] REPEAT_LAST = CNT_WIDTH'(REPEAT_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE     = CNT_WIDTH'(1);

  btn_state_e           state_q, state_d;
  logic [CNT_WIDTH-1:0] timer_q, timer_d;
  logic                 in_prev_q;
  logic                 press_q, press_d;
  logic                 release_q, release_d;
  logic                 long_q, long_d;
  logic                 repeat_q, repeat_d;
  logic                 held_q, held_d;
  logic                 long_held_q, long_held_d;
  logic                 rise, fall;

  assign rise = in & ~in_prev_q;
  assign fall = ~in & in_prev_q;

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;
    repeat_d  = 1'b0;

    // Disable overrides everything, including a pending release.
    if (!en) begin
      state_d = ST_IDLE;
      timer_d = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          timer_d = '0;
          if (rise) begin
            state_d = ST_PRESSED;
            press_d = 1'b1;
          end
        end
        ST_PRESSED: begin
          if (fall) begin
            state_d   = ST_IDLE;
            timer_d   = '0;
            release_d = 1'b1;
          end else if (timer_q == LONG_LAST) begin
            state_d = ST_REPEATING;
            timer_d = '0;
            long_d  = 1'b1;
          end else begin
            timer_d = timer_q + CNT_ONE;
          end
        end
        ST_REPEATING: begin
          if (fall) begin
            state_d   = ST_IDLE;
            timer_d   = '0;
            release_d = 1'b1;
          end else if (REPEAT_EN && timer_q == REPEAT_LAST) begin
            timer_d  = '0;
            repeat_d = 1'b1;
          end else if (REPEAT_EN || timer_q != '1) begin
            timer_d = timer_q + CNT_ONE;
          end
        end
        default: begin
          state_d = ST_IDLE;
          timer_d = '0;
        end
      endcase
    end

    held_d      = (state_d != ST_IDLE);
    long_held_d = (state_d == ST_REPEATING);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      timer_q     <= '0;
      in_prev_q   <= 1'b0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      long_q      <= 1'b0;
      repeat_q    <= 1'b0;
      held_q      <= 1'b0;
      long_held_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      in_prev_q   <= in;
      press_q     <= press_d;
      release_q   <= release_d;
      long_q      <= long_d;
      repeat_q    <= repeat_d;
      held_q      <= held_d;
      long_held_q <= long_held_d;
    end
  end

  assign press       = press_q;
  assign release_evt = release_q;
  assign long_press  = long_q;
  assign repeat_evt  = repeat_q;
  assign held        = held_q;
  assign long_held   = long_held_q;

endmodule

// File: tb/tb_button_event_gen.sv
// Bench for button_event_gen: directed hold scenarios plus random stimulus,
// checked every cycle against a hold-age model for REPEAT_EN=1 and 0.
module tb_button_event_gen;

  localparam int unsigned L = 8;
  localparam int unsigned R = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic en;
  logic in;

  logic p0, r0, l0, t0, h0, lh0;
  logic p1, r1, l1, t1, h1, lh1;
  logic [5:0] obs [2];

  int compared   = 0;
  int mismatched = 0;

  // Reference model state per instance (index 0: repeat on, 1: repeat off)
  bit          m_active [2];
  int unsigned m_age    [2];
  bit          m_prev   [2];

  always #5 clk = ~clk;

  button_event_gen #(.CNT_WIDTH(16), .LONG_CYCLES(L), .REPEAT_CYCLES(R), .REPEAT_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .in(in),
    .press(p0), .release_evt(r0), .long_press(l0), .repeat_evt(t0),
    .held(h0), .long_held(lh0)
  );

  button_event_gen #(.CNT_WIDTH(16), .LONG_CYCLES(L), .REPEAT_CYCLES(R), .REPEAT_EN(1'b0)) dut_nr (
    .clk(clk), .rst_n(rst_n), .en(en), .in(in),
    .press(p1), .release_evt(r1), .long_press(l1), .repeat_evt(t1),
    .held(h1), .long_held(lh1)
  );

  assign obs[0] = {p0, r0, l0, t0, h0, lh0};
  assign obs[1] = {p1, r1, l1, t1, h1, lh1};

  task automatic check(input string tag, input logic [5:0] got, input logic [5:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s @%0t: got {press,rel,long,rep,held,lheld}=%b expected %b",
               tag, $time, got, exp);
    end
  endtask

  function automatic logic [5:0] model_step(input int i, input bit rep_en);
    bit p = 0, rl = 0, lp = 0, rp = 0;
    bit rise = in && !m_prev[i];
    bit fall = !in && m_prev[i];
    if (!en) begin
      m_active[i] = 0;
    end else if (!m_active[i]) begin
      if (rise) begin
        m_active[i] = 1;
        m_age[i]    = 0;
        p           = 1;
      end
    end else begin
      m_age[i]++;
      if (fall) begin
        m_active[i] = 0;
        rl          = 1;
      end else if (m_age[i] == L) begin
        lp = 1;
      end else if (rep_en && m_age[i] > L && (m_age[i] - L) % R == 0) begin
        rp = 1;
      end
    end
    m_prev[i] = in;
    return {p, rl, lp, rp, m_active[i], m_active[i] && m_age[i] >= L};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_active[i] = 0;
      m_age[i]    = 0;
      m_prev[i]   = 0;
    end
  endtask

  task automatic cycle();
    logic [5:0] e0, e1;
    @(posedge clk);
    e0 = model_step(0, 1'b1);
    e1 = model_step(1, 1'b0);
    #1;
    check("rep_on", obs[0], e0);
    check("rep_off", obs[1], e1);
  endtask

  task automatic drive(input logic in_v, input logic en_v, input int n);
    for (int c = 0; c < n; c++) begin
      in = in_v;
      en = en_v;
      cycle();
    end
  endtask

  // Called just after a checked edge: resets mid-cycle and releases before the next edge.
  task automatic async_reset();
    #3 rst_n = 1'b0;
    #1;
    check("async_rst0", obs[0], 6'b0);
    check("async_rst1", obs[1], 6'b0);
    model_reset();
    #2 rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    in    = 1'b0;
    en    = 1'b0;
    model_reset();
    #2;
    check("reset0", obs[0], 6'b0);
    check("reset1", obs[1], 6'b0);
    @(posedge clk);
    #2 rst_n = 1'b1;

    drive(0, 1, 3);
    // short press
    drive(1, 1, 3);  drive(0, 1, 3);
    // long hold with repeats
    drive(1, 1, 20); drive(0, 1, 3);
    // fall coincides with long threshold
    drive(1, 1, 8);  drive(0, 1, 3);
    // fall coincides with first repeat threshold
    drive(1, 1, 12); drive(0, 1, 3);
    // enable gating, no press on re-enable, then a fresh rise
    drive(1, 1, 5);  drive(1, 0, 5);  drive(1, 1, 4);
    drive(0, 1, 2);  drive(1, 1, 3);  drive(0, 1, 2);
    // long hold where only the repeat-enabled instance repeats
    drive(1, 1, 30); drive(0, 1, 3);
    // async reset during REPEATING, then re-press
    drive(1, 1, 10);
    async_reset();
    drive(1, 1, 2);  drive(0, 1, 3);

    for (int it = 0; it < 300; it++) begin
      int hi_len = $urandom_range(1, 35);
      int lo_len = $urandom_range(1, 6);
      logic en_hi = ($urandom_range(0, 9) != 0);
      drive(1, en_hi, hi_len);
      if ($urandom_range(0, 29) == 0) async_reset();
      drive(0, ($urandom_range(0, 9) != 0), lo_len);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
